// File: rtl/event_list_arbiter.sv
// rtl/event_list_arbiter.sv - round-robin arbiter with bounded hold, one-cycle gap and registered payload mux
// A grant is held while the owner keeps requesting, up to MAX_HOLD cycles.
module event_list_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   din,
  output logic [N_REQ-1:0]          gnt,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [IDX_W-1:0]   own_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [7:0]         hold_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   ptr_d;
  logic [IDX_W-1:0]   cand;

  // Scan from the farthest slot back toward ptr so the nearest set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_q) + k >= N_REQ) ? IDX_W'(int'(ptr_q) + k - N_REQ)
                                        : IDX_W'(int'(ptr_q) + k);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    ptr_d = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      own_q       <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      // Payload path trails the grant by one cycle.
      out_valid_q <= (state_q == GRANT);
      if (state_q == GRANT) out_q <= din[own_q*DATA_W +: DATA_W];

      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q        <= GRANT;
            gnt_q          <= '0;
            gnt_q[win_idx] <= 1'b1;
            own_q          <= win_idx;
            ptr_q          <= ptr_d;
            hold_q         <= 8'd1;
          end
        end
        GRANT: begin
          if (!req[own_q] || hold_q >= 8'(MAX_HOLD)) begin
            state_q <= GAP;
            gnt_q   <= '0;
          end else if (hold_q != 8'hFF) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_event_list_arbiter.sv
// tb/tb_event_list_arbiter.sv - randomized and directed bench for event_list_arbiter against a behavioural model
// Two instances share inputs: default MAX_HOLD and MAX_HOLD = 1.
module tb_event_list_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*DW-1:0] din;

  logic [N-1:0]   gnt0, gnt1;
  logic           ov0, ov1;
  logic [DW-1:0]  out0, out1;
  logic           busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  event_list_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt0), .out_valid(ov0), .out(out0), .busy(busy0)
  );

  event_list_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(gnt1), .out_valid(ov1), .out(out1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 granted, 2 gap; one slot per instance.
  int            m_phase [2];
  int            m_owner [2];
  int            m_held  [2];
  int            m_next  [2];
  logic          m_ov    [2];
  logic [DW-1:0] m_out   [2];
  int            m_limit [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int m);
    int pick;
    if (rst) begin
      m_phase[m] = 0; m_owner[m] = 0; m_held[m] = 0; m_next[m] = 0;
      m_ov[m] = 1'b0; m_out[m] = '0;
      return;
    end
    m_ov[m] = (m_phase[m] == 1);
    if (m_phase[m] == 1) m_out[m] = din[m_owner[m]*DW +: DW];
    if (m_phase[m] == 0) begin
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && req[(m_next[m] + k) % N]) pick = (m_next[m] + k) % N;
      if (pick >= 0) begin
        m_phase[m] = 1; m_owner[m] = pick; m_held[m] = 1; m_next[m] = (pick + 1) % N;
      end
    end else if (m_phase[m] == 1) begin
      if (!req[m_owner[m]] || m_held[m] >= m_limit[m]) m_phase[m] = 2;
      else m_held[m] = m_held[m] + 1;
    end else begin
      m_phase[m] = 0;
    end
  endtask

  function automatic logic [N-1:0] exp_gnt(input int m);
    return (m_phase[m] == 1) ? N'(1) << m_owner[m] : '0;
  endfunction

  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic [N*DW-1:0] d);
    @(negedge clk);
    rst = r; req = rq; din = d;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check("gnt0",  gnt0,  exp_gnt(0));
    check("ov0",   ov0,   m_ov[0]);
    check("out0",  out0,  m_out[0]);
    check("busy0", busy0, m_phase[0] != 0);
    check("gnt1",  gnt1,  exp_gnt(1));
    check("ov1",   ov1,   m_ov[1]);
    check("out1",  out1,  m_out[1]);
    check("busy1", busy1, m_phase[1] != 0);
    check("onehot0", $countones(gnt0) <= 1, 1);
    check("onehot1", $countones(gnt1) <= 1, 1);
  endtask

  localparam logic [N*DW-1:0] DIN_FIX = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

  initial begin
    logic [N-1:0] rq;
    logic [N*DW-1:0] rd;
    m_limit[0] = 8;
    m_limit[1] = 1;
    rst = 1'b1; req = '0; din = '0;

    cyc(1'b1, 4'b0000, DIN_FIX);
    cyc(1'b1, 4'b0000, DIN_FIX);
    check("rst_gnt",  gnt0,  0);
    check("rst_ov",   ov0,   0);
    check("rst_out",  out0,  0);
    check("rst_busy", busy0, 0);

    // All requesting: a, b, c, d each for 8 cycles with gaps.
    for (int i = 0; i < 45; i++) cyc(1'b0, 4'b1111, DIN_FIX);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, DIN_FIX);

    // Short c pulse.
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, DIN_FIX);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, DIN_FIX);

    // b owns, d arrives mid-grant and must wait.
    for (int i = 0; i < 2; i++) cyc(1'b0, 4'b0010, DIN_FIX);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1010, DIN_FIX);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b1000, DIN_FIX);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0000, DIN_FIX);

    // Reset on the third grant cycle of c, then c and d compete.
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, DIN_FIX);
    cyc(1'b1, 4'b0100, DIN_FIX);
    check("midrst_gnt", gnt0, 0);
    check("midrst_ov",  ov0,  0);
    cyc(1'b0, 4'b1100, DIN_FIX);
    check("after_rst_c", gnt0, 4'b0100);
    for (int i = 0; i < 12; i++) cyc(1'b0, 4'b1100, DIN_FIX);

    // Request drop coincides with the hold limit.
    cyc(1'b1, 4'b0000, DIN_FIX);
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'b0001, DIN_FIX);
    cyc(1'b0, 4'b0000, DIN_FIX);
    check("limit_gap", busy0, 1);
    cyc(1'b0, 4'b0010, DIN_FIX);
    check("limit_idle", gnt0, 0);
    cyc(1'b0, 4'b0010, DIN_FIX);
    check("limit_next_b", gnt0, 4'b0010);

    // Two requesters constant: MAX_HOLD = 1 instance alternates a, b.
    cyc(1'b1, 4'b0000, DIN_FIX);
    for (int i = 0; i < 18; i++) cyc(1'b0, 4'b0011, DIN_FIX);

    // Randomized traffic with sticky requests and rare resets.
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) rq[b] = ~rq[b];
      rd = {$urandom, $urandom};
      cyc($urandom_range(149) == 0, rq, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
